// File: rtl/oc8051_iram_pkg.sv
// Shared definitions for the 8051 internal RAM and its March C- self-test sequencer.
// The self-test is compiled in only when OC8051_IRAM_BIST_EN is defined.
package oc8051_iram_pkg;

  typedef enum logic [2:0] {
    BIST_IDLE = 3'd0,
    BIST_M0   = 3'd1,
    BIST_M1   = 3'd2,
    BIST_M2   = 3'd3,
    BIST_M3   = 3'd4,
    BIST_M4   = 3'd5,
    BIST_M5   = 3'd6,
    BIST_DONE = 3'd7
  } bist_state_e;

  // Per-element attributes, one bit per state encoding.
  localparam logic [7:0] ELEM_DOWN_MASK = 8'b0111_0000;  // M3, M4, M5 run downwards
  localparam logic [7:0] ELEM_RPAT_MASK = 8'b0010_1000;  // M2, M4 expect ones
  localparam logic [7:0] ELEM_WPAT_MASK = 8'b0001_0100;  // M1, M3 write ones

  function automatic logic elem_down(bist_state_e s);
    return ELEM_DOWN_MASK[s];
  endfunction

  function automatic logic elem_rpat(bist_state_e s);
    return ELEM_RPAT_MASK[s];
  endfunction

  function automatic logic elem_wpat(bist_state_e s);
    return ELEM_WPAT_MASK[s];
  endfunction

  function automatic bist_state_e elem_next(bist_state_e s);
    bist_state_e n;
    case (s)
      BIST_M0: n = BIST_M1;
      BIST_M1: n = BIST_M2;
      BIST_M2: n = BIST_M3;
      BIST_M3: n = BIST_M4;
      BIST_M4: n = BIST_M5;
      BIST_M5: n = BIST_DONE;
      default: n = s;
    endcase
    return n;
  endfunction

  function automatic int unsigned bist_cycles(int unsigned depth);
    return 11 * depth;
  endfunction

endpackage

// File: rtl/oc8051_iram_bist_gen_bist_fsm.sv
// March C- sequencer, address counter, comparator and sticky result flags.
// Built only with OC8051_IRAM_BIST_EN; otherwise every output is tied to 0.
module oc8051_iram_bist_fsm
  import oc8051_iram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_start_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

`ifdef OC8051_IRAM_BIST_EN
  bist_state_e       state_q;
  bist_state_e       state_nxt_d;
  logic              phase_q;  // 0: read cycle, 1: compare(+write) cycle
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q, done_q, fail_q;
  logic [ADDR_W-1:0] fail_addr_q;

  logic              in_test, rw_elem, step, last;
  logic [DATA_W-1:0] exp_w;

  assign in_test     = (state_q != BIST_IDLE) && (state_q != BIST_DONE);
  assign rw_elem     = (state_q != BIST_M0);
  assign step        = in_test && (!rw_elem || phase_q);
  assign last        = elem_down(state_q) ? (addr_q == '0) : (addr_q == '1);
  assign exp_w       = {DATA_W{elem_rpat(state_q)}};
  assign state_nxt_d = elem_next(state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BIST_IDLE;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else if (!in_test) begin
      if (bist_start_i) begin
        state_q     <= BIST_M0;
        phase_q     <= 1'b0;
        addr_q      <= '0;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
      end
    end else begin
      if (rw_elem && phase_q && (rdata_i != exp_w)) begin
        fail_q <= 1'b1;
        if (!fail_q) fail_addr_q <= addr_q;
      end
      if (rw_elem) phase_q <= ~phase_q;
      if (step) begin
        if (last) begin
          // Counter restarts at the first address of the next element's direction.
          state_q <= state_nxt_d;
          addr_q  <= elem_down(state_nxt_d) ? '1 : '0;
          if (state_q == BIST_M5) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else if (elem_down(state_q)) begin
          addr_q <= addr_q - ADDR_W'(1);
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign mem_re_o    = in_test && rw_elem && !phase_q;
  assign mem_we_o    = in_test && (!rw_elem || (phase_q && (state_q != BIST_M5)));
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = {DATA_W{elem_wpat(state_q)}};
`else
  logic unused_ok;
  assign unused_ok   = ^{clk, rst, bist_start_i, rdata_i};
  assign busy_o      = 1'b0;
  assign done_o      = 1'b0;
  assign fail_o      = 1'b0;
  assign fail_addr_o = '0;
  assign mem_we_o    = 1'b0;
  assign mem_re_o    = 1'b0;
  assign mem_addr_o  = '0;
  assign mem_wdata_o = '0;
`endif

endmodule

// File: rtl/oc8051_iram_bist_gen.sv
// 8051 internal RAM: one write port, two registered read ports with write bypass,
// flattened snapshot bus, optional March C- self-test (OC8051_IRAM_BIST_EN).
module oc8051_iram_bist_gen
  import oc8051_iram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd0_en,
  input  logic                          rd1_en,
  input  logic [ADDR_W-1:0]             rd0_addr,
  input  logic [ADDR_W-1:0]             rd1_addr,
  output logic [DATA_W-1:0]             rd0_data,
  output logic [DATA_W-1:0]             rd1_data,
  output logic [(2**ADDR_W)*DATA_W-1:0] iram,
  input  logic                          bist_start,
  output logic                          bist_busy,
  output logic                          bist_done,
  output logic                          bist_fail,
  output logic [ADDR_W-1:0]             bist_fail_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] iram_w;
  logic [DEPTH*DATA_W-1:0] flt_or;  // stuck-at-1 injection point, tied off in normal use

  logic [DATA_W-1:0] rd0_q, rd1_q, bist_rd_q;
  logic              bist_we, bist_re;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              func_wr, func_rd0, func_rd1;

  assign flt_or = '0;

  oc8051_iram_bist_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bist (
    .clk         (clk),
    .rst         (rst),
    .bist_start_i(bist_start),
    .rdata_i     (bist_rd_q),
    .busy_o      (bist_busy),
    .done_o      (bist_done),
    .fail_o      (bist_fail),
    .fail_addr_o (bist_fail_addr),
    .mem_we_o    (bist_we),
    .mem_re_o    (bist_re),
    .mem_addr_o  (bist_addr),
    .mem_wdata_o (bist_wdata)
  );

  assign func_wr  = wr && !bist_busy;
  assign func_rd0 = rd0_en && !bist_busy;
  assign func_rd1 = rd1_en && !bist_busy;

  always_comb begin
    we    = func_wr;
    waddr = wr_addr;
    wdata = wr_data;
    if (bist_we) begin
      we    = 1'b1;
      waddr = bist_addr;
      wdata = bist_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    iram_w = '0;
    for (int k = 0; k < DEPTH; k++) iram_w[k*DATA_W +: DATA_W] = mem_q[k];
  end

  assign iram = iram_w | flt_or;

  // Functional reads; a same-cycle write to the same word is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (func_rd0)
        rd0_q <= (func_wr && (wr_addr == rd0_addr)) ? wr_data
                                                    : iram[int'(rd0_addr)*DATA_W +: DATA_W];
      if (func_rd1)
        rd1_q <= (func_wr && (wr_addr == rd1_addr)) ? wr_data
                                                    : iram[int'(rd1_addr)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (bist_re) bist_rd_q <= iram[int'(bist_addr)*DATA_W +: DATA_W];
  end

  assign rd0_data = rd0_q;
  assign rd1_data = rd1_q;

endmodule

// File: tb/tb_oc8051_iram_bist_gen.sv
// Directed + randomized bench for oc8051_iram_bist_gen (DATA_W=8, ADDR_W=4),
// with self-test scenarios when OC8051_IRAM_BIST_EN is defined.
module tb_oc8051_iram_bist_gen;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int IW    = DEPTH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd0_en, rd1_en;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic [DW-1:0] rd0_data, rd1_data;
  logic [IW-1:0] iram;
  logic          bist_start;
  logic          bist_busy, bist_done, bist_fail;
  logic [AW-1:0] bist_fail_addr;

  oc8051_iram_bist_gen #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd1_en(rd1_en), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .iram(iram),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [DW-1:0] m [DEPTH];
  logic [DW-1:0] e0, e1;

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] model_flat();
    logic [IW-1:0] f;
    f = '0;
    for (int k = 0; k < DEPTH; k++) f[k*DW +: DW] = m[k];
    return f;
  endfunction

  // Reference behaviour of one functional cycle: reads see the old word unless
  // the same word is written in that cycle; disabled ports keep their value.
  task automatic func_cycle();
    if (rd0_en) e0 = (wr && wr_addr == rd0_addr) ? wr_data : m[rd0_addr];
    if (rd1_en) e1 = (wr && wr_addr == rd1_addr) ? wr_data : m[rd1_addr];
    if (wr) m[wr_addr] = wr_data;
    tick();
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0; bist_start = 1'b0;
  endtask

`ifdef OC8051_IRAM_BIST_EN
  // Starts a self-test and counts cycles with busy high while hammering the
  // functional ports (all of which must be ignored) and re-pulsing start.
  task automatic run_bist(output int n);
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    n = 0;
    while (bist_busy === 1'b1 && n < 4 * 11 * DEPTH) begin
      n++;
      bist_start = (n == 60);
      wr = 1'b1; wr_addr = AW'($urandom); wr_data = 8'hFF;
      rd0_en = 1'b1; rd0_addr = AW'($urandom);
      rd1_en = 1'b1; rd1_addr = AW'($urandom);
      tick();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    int n;
    rst = 1'b1;
    wr_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
    idle_inputs();
    e0 = '0; e1 = '0;
    tick(); tick();
    chk("reset_rd0", rd0_data, 0);
    chk("reset_rd1", rd1_data, 0);
    chk("reset_busy", bist_busy, 0);
    chk("reset_done", bist_done, 0);
    chk("reset_fail", bist_fail, 0);
    chk("reset_fail_addr", bist_fail_addr, 0);
    rst = 1'b0;
    tick();

    // Fill every word so later reads are defined.
    for (int a = 0; a < DEPTH; a++) begin
      wr = 1'b1; wr_addr = AW'(a); wr_data = DW'($urandom);
      func_cycle();
    end
    wr = 1'b0;
    chk("fill_iram", iram, model_flat());

    // Write then read on the following cycle.
    wr = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    func_cycle();
    wr = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd3;
    func_cycle();
    rd0_en = 1'b0;
    chk("wr_then_rd0", rd0_data, 8'hA5);

    // Same-cycle write with both ports reading that word.
    wr = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    rd0_en = 1'b1; rd0_addr = 4'd7; rd1_en = 1'b1; rd1_addr = 4'd7;
    func_cycle();
    idle_inputs();
    chk("bypass_rd0", rd0_data, 8'h3C);
    chk("bypass_rd1", rd1_data, 8'h3C);
    chk("iram_slice7", iram[63:56], 8'h3C);

    // Randomized functional traffic.
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      rd0_en = 1'($urandom); rd1_en = 1'($urandom);
      rd0_addr = AW'($urandom); rd1_addr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd1_addr = rd0_addr;
      if ($urandom_range(0, 3) == 0) wr_addr = rd0_addr;
      func_cycle();
      chk("rand_rd0", rd0_data, e0);
      chk("rand_rd1", rd1_data, e1);
      if (i % 25 == 0) chk("rand_iram", iram, model_flat());
    end
    idle_inputs();
    chk("rand_iram_end", iram, model_flat());

`ifdef OC8051_IRAM_BIST_EN
    // Healthy array.
    run_bist(n);
    chk("bist_cycles", n, 11 * DEPTH);
    chk("bist_done", bist_done, 1);
    chk("bist_fail", bist_fail, 0);
    chk("bist_iram_zero", iram, 0);
    chk("bist_rd0_hold", rd0_data, e0);
    chk("bist_rd1_hold", rd1_data, e1);
    for (int k = 0; k < DEPTH; k++) m[k] = '0;

    // Stuck-at-1 on bit 2 of word 5.
    force dut.flt_or = 128'h0000_0000_0000_0000_0000_0400_0000_0000;
    run_bist(n);
    chk("flt_cycles", n, 11 * DEPTH);
    chk("flt_done", bist_done, 1);
    chk("flt_fail", bist_fail, 1);
    chk("flt_fail_addr", bist_fail_addr, 5);
    release dut.flt_or;

    // Reset in the middle of a run.
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    chk("abort_busy_start", bist_busy, 1);
    for (int c = 1; c < 40; c++) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", bist_busy, 0);
    chk("abort_done", bist_done, 0);
    chk("abort_fail", bist_fail, 0);
    chk("abort_fail_addr", bist_fail_addr, 0);
    chk("abort_rd0", rd0_data, 0);
    chk("abort_rd1", rd1_data, 0);
    tick();
    rst = 1'b0;
    e0 = '0; e1 = '0;
    tick();
    run_bist(n);
    chk("rerun_cycles", n, 11 * DEPTH);
    chk("rerun_done", bist_done, 1);
    chk("rerun_fail", bist_fail, 0);
    chk("rerun_iram_zero", iram, 0);
    for (int k = 0; k < DEPTH; k++) m[k] = '0;
`else
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("nobist_busy", bist_busy, 0);
      tick();
    end
    chk("nobist_done", bist_done, 0);
    chk("nobist_fail", bist_fail, 0);
    chk("nobist_fail_addr", bist_fail_addr, 0);
`endif

    // Functional ports usable after the self-test section.
    wr = 1'b1; wr_addr = 4'd9; wr_data = 8'h5A;
    func_cycle();
    wr = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd9; rd1_en = 1'b1; rd1_addr = 4'd2;
    func_cycle();
    idle_inputs();
    chk("post_rd0", rd0_data, 8'h5A);
    chk("post_rd1", rd1_data, e1);
    chk("post_iram", iram, model_flat());

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
